// File: rtl/mux_scan_seq_pkg.sv
// Shared constants and state encoding for the mux scan sequencer and the
// 7:1 mux it drives.
package mux_scan_seq_pkg;

    localparam int NUM_CH_DEF     = 7;
    localparam int SEL_W_DEF      = 3;
    localparam int SETTLE_CYC_DEF = 2;
    localparam int WAIT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mux_scan_seq_if.sv
// Control/data bundle between the scan sequencer, its controller and the mux.
interface mux_scan_seq_if
    import mux_scan_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF
) ();

    logic              start;
    logic              y;
    logic [SEL_W-1:0]  s;
    logic              busy;
    logic [NUM_CH-1:0] data_out;
    logic              valid;

    modport master (
        output start,
        output y,
        input  s,
        input  busy,
        input  data_out,
        input  valid
    );

    modport slave (
        input  start,
        input  y,
        output s,
        output busy,
        output data_out,
        output valid
    );

endinterface

// File: rtl/mux_7x1.sv
// 7:1 single-bit multiplexer; unused select codes yield 0.
module mux_7x1 (
    input  logic [6:0] i,
    input  logic [2:0] s,
    output logic       y
);

    // channel select
    always_comb begin
        y = 1'b0;
        case (s)
            3'd0:    y = i[0];
            3'd1:    y = i[1];
            3'd2:    y = i[2];
            3'd3:    y = i[3];
            3'd4:    y = i[4];
            3'd5:    y = i[5];
            3'd6:    y = i[6];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_scan_wait_cnt.sv
// Settle-interval counter: clear has priority over enable; tc flags the
// last settle cycle.
module mux_scan_wait_cnt
    import mux_scan_seq_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [WAIT_W-1:0] cnt,
    output logic              tc
);

    localparam logic [WAIT_W-1:0] TC_VAL = WAIT_W'(SETTLE_CYC - 1);
    localparam logic [WAIT_W-1:0] ONE    = WAIT_W'(1);

    logic [WAIT_W-1:0] cnt_r;
    logic [WAIT_W-1:0] cnt_nxt_s;

    // next count selection
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = '0;
        end else if (en) begin
            cnt_nxt_s = cnt_r + ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == TC_VAL);

endmodule

// File: rtl/mux_scan_seq.sv
// Steps the mux select through every channel, samples y after a settle
// interval, and publishes the assembled snapshot with a one-cycle valid.
module mux_scan_seq
    import mux_scan_seq_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_scan_seq_if.slave bus
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    scan_state_t       state_r;
    scan_state_t       state_nxt_s;
    logic [SEL_W-1:0]  s_r;
    logic [SEL_W-1:0]  s_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic [NUM_CH-1:0] data_out_r;
    logic [NUM_CH-1:0] data_nxt_s;
    logic [NUM_CH-1:0] buf_r;
    logic [NUM_CH-1:0] buf_nxt_s;
    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic              cnt_tc_s;
    logic [WAIT_W-1:0] cnt_s;

    mux_scan_wait_cnt #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .cnt   (cnt_s),
        .tc    (cnt_tc_s)
    );

    // next-state and next-output logic
    always_comb begin
        state_nxt_s = state_r;
        s_nxt_s     = s_r;
        buf_nxt_s   = buf_r;
        data_nxt_s  = data_out_r;
        valid_nxt_s = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                s_nxt_s = '0;
                if (bus.start) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_clr_s   = 1'b1;
                    buf_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_en_s = 1'b1;
                if (cnt_tc_s) begin
                    state_nxt_s = ST_SAMPLE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (SEL_W'(k) == s_r) begin
                        buf_nxt_s[k] = bus.y;
                    end else begin
                        buf_nxt_s[k] = buf_r[k];
                    end
                end
                cnt_clr_s = 1'b1;
                if (s_r == LAST_SEL) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    s_nxt_s     = s_r + SEL_ONE;
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                data_nxt_s  = buf_r;
                valid_nxt_s = 1'b1;
                s_nxt_s     = '0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                s_nxt_s     = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
        // busy spans every non-idle state, so it follows the next state
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            s_r        <= '0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            data_out_r <= '0;
            buf_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            s_r        <= s_nxt_s;
            busy_r     <= busy_nxt_s;
            valid_r    <= valid_nxt_s;
            data_out_r <= data_nxt_s;
            buf_r      <= buf_nxt_s;
        end
    end

    assign bus.s        = s_r;
    assign bus.busy     = busy_r;
    assign bus.valid    = valid_r;
    assign bus.data_out = data_out_r;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench: scan sequencer driving the 7:1 mux, inputs from the bench.
module tb_mux_scan_seq;

    logic       clk;
    logic       rst_n;
    logic [6:0] i_vec;
    int         checks;
    int         errors;
    int         cyc;
    int         vcount;
    int         last_valid;
    int         prev_valid;
    logic [6:0] exp_q[$];

    mux_scan_seq_if bus ();

    mux_scan_seq u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mux_7x1 u_mux (
        .i (i_vec),
        .s (bus.s),
        .y (bus.y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every valid pulse pops one expected snapshot
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            vcount++;
            prev_valid = last_valid;
            last_valid = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: data_out %0h with nothing expected", bus.data_out);
            end else begin
                chk("data_out", int'(bus.data_out), int'(exp_q.pop_front()));
            end
        end
    end

    // one scan starting at edge 0; optional start pokes at edges 5 and 10
    task automatic run_scan(input logic [6:0] pat, input bit pokes);
        int t0;
        int es;
        @(negedge clk);
        i_vec     = pat;
        bus.start = 1'b1;
        exp_q.push_back(pat);
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
        for (int e = 0; e <= 23; e++) begin
            es = (e <= 21) ? ((e / 3 > 6) ? 6 : e / 3) : 0;
            chk("s_step", int'(bus.s), es);
            chk("busy", int'(bus.busy), (e <= 21) ? 1 : 0);
            if (pokes && (e == 4 || e == 9)) bus.start = 1'b1;
            else bus.start = 1'b0;
            @(negedge clk);
        end
        chk("valid_time", last_valid - t0, 22);
    endtask

    initial begin
        int vbase;
        int t0;
        checks = 0; errors = 0; cyc = 0; vcount = 0;
        last_valid = -1; prev_valid = -1;
        rst_n = 1'b0; bus.start = 1'b1; i_vec = 7'b0000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s", int'(bus.s), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_data", int'(bus.data_out), 0);
        rst_n = 1'b1; bus.start = 1'b0;
        repeat (2) @(negedge clk);

        run_scan(7'b1010011, 1'b0);
        run_scan(7'b0000001, 1'b0);
        run_scan(7'b1000000, 1'b0);

        vbase = vcount;
        run_scan(7'b0110011, 1'b1);
        repeat (4) @(negedge clk);
        chk("poke_one_valid", vcount - vbase, 1);

        // reset at edge 9 of a scan
        vbase = vcount;
        @(negedge clk);
        i_vec = 7'b1111111; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_data", int'(bus.data_out), 0);
        chk("midrst_s", int'(bus.s), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_no_valid", vcount - vbase, 0);
        run_scan(7'b1111111, 1'b0);

        // start held high: back-to-back scans
        @(negedge clk);
        i_vec = 7'h55; bus.start = 1'b1;
        exp_q.push_back(7'h55);
        exp_q.push_back(7'h2A);
        @(negedge clk);
        t0 = cyc;
        repeat (22) @(negedge clk);
        i_vec = 7'h2A;
        repeat (23) @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_gap", last_valid - prev_valid, 23);
        chk("b2b_second_time", last_valid - t0, 45);
        repeat (30) @(negedge clk);
        chk("b2b_idle_busy", int'(bus.busy), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
